// File: rtl/axi_sys_bridge.sv
// axi_sys_bridge
//
// AXI slave that accepts single-beat AXI reads and writes. It turns each one
// into a one-cycle strobe on the simple system register bus, waits for the
// peripheral to ack or flag an error, and then returns the AXI response.
//
// Parameters
//   IW  : AXI ID width. AWID/ARID are echoed on BID/RID.
//   TMO : ack timeout in clock cycles, counted from the strobe cycle
//         (legal range 1..255).
//
// Optional feature macro
//   AXI_SYS_BRIDGE_TMO_EN : when defined, an ACC state that sees neither ack
//                           nor err within TMO cycles ends with SLVERR.
//                           When undefined, the ACC states wait indefinitely
//                           and TMO is not used.
//
// Ports
//   aclk_i, arst_i               : clock and asynchronous active-high reset
//   aw*_i / awready_o            : write address channel
//   w*_i  / wready_o             : write data channel (every beat is last)
//   bid_o, bresp_o, bvalid_o,
//   bready_i                     : write response channel
//   ar*_i / arready_o            : read address channel
//   rid_o, rdata_o, rresp_o,
//   rlast_o, rvalid_o, rready_i  : read data channel
//   sys_addr_o, sys_wdata_o,
//   sys_sel_o                    : latched address, write data, byte select
//   sys_wen_o, sys_ren_o         : one-cycle write / read strobes
//   sys_rdata_i, sys_err_i,
//   sys_ack_i                    : peripheral read data, error and done
//
// Every output comes straight from a register.

module axi_sys_bridge #(
  parameter int IW  = 4,
  parameter int TMO = 16
) (
  input  logic          aclk_i,
  input  logic          arst_i,
  input  logic [IW-1:0] awid_i,
  input  logic [31:0]   awaddr_i,
  input  logic          awvalid_i,
  output logic          awready_o,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  output logic [IW-1:0] bid_o,
  output logic [1:0]    bresp_o,
  output logic          bvalid_o,
  input  logic          bready_i,
  input  logic [IW-1:0] arid_i,
  input  logic [31:0]   araddr_i,
  input  logic          arvalid_i,
  output logic          arready_o,
  output logic [IW-1:0] rid_o,
  output logic [31:0]   rdata_o,
  output logic [1:0]    rresp_o,
  output logic          rlast_o,
  output logic          rvalid_o,
  input  logic          rready_i,
  output logic [31:0]   sys_addr_o,
  output logic [31:0]   sys_wdata_o,
  output logic [3:0]    sys_sel_o,
  output logic          sys_wen_o,
  output logic          sys_ren_o,
  input  logic [31:0]   sys_rdata_i,
  input  logic          sys_err_i,
  input  logic          sys_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RESP,
    RD_ACC,
    RD_RESP
  } state_t;

  state_t        state_q;
  logic          strobed_q;
  logic          awready_q;
  logic          wready_q;
  logic          arready_q;
  logic [IW-1:0] bid_q;
  logic [IW-1:0] rid_q;
  logic [1:0]    bresp_q;
  logic [1:0]    rresp_q;
  logic          bvalid_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic [31:0]   sysAddr_q;
  logic [31:0]   sysWdata_q;
  logic [3:0]    sysSel_q;
  logic          sysWen_q;
  logic          sysRen_q;

  logic          tmoHit;
  logic          accDone;
  logic          accErr;

`ifdef AXI_SYS_BRIDGE_TMO_EN
  localparam logic [7:0] TmoLast = 8'(TMO - 1);

  logic [7:0] tmoCnt_q;

  // Cleared on the edge that raises the strobe, so in the strobe cycle the
  // count is 0. When the count reaches TMO-1 with no ack, the response
  // appears in cycle strobe+TMO. The count saturates, so it cannot wrap.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      tmoCnt_q <= '0;
    end else if ((state_q == WR_ACC || state_q == RD_ACC) && !strobed_q) begin
      tmoCnt_q <= '0;
    end else if (tmoCnt_q != TmoLast) begin
      tmoCnt_q <= tmoCnt_q + 8'd1;
    end
  end

  assign tmoHit = (tmoCnt_q == TmoLast);
`else
  assign tmoHit = 1'b0;
`endif

  // err wins over ack. An ack that arrives in the timeout cycle still counts
  // as in time.
  assign accDone = sys_err_i | sys_ack_i | tmoHit;
  assign accErr  = sys_err_i | (~sys_ack_i & tmoHit);

  // Main FSM. The ready pulses and the sys strobes default low every cycle.
  // Each ACC state takes two steps. In its first cycle the AXI ready pulse is
  // visible and the strobe is raised. From the strobe cycle on, ack/err are
  // sampled.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      strobed_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bid_q      <= '0;
      rid_q      <= '0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      sysAddr_q  <= '0;
      sysWdata_q <= '0;
      sysSel_q   <= '0;
      sysWen_q   <= 1'b0;
      sysRen_q   <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      sysWen_q  <= 1'b0;
      sysRen_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          // A write is accepted only when AW and W are both present.
          // A lone AW or W does not block a pending read.
          if (awvalid_i && wvalid_i) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bid_q      <= awid_i;
            sysAddr_q  <= awaddr_i;
            sysWdata_q <= wdata_i;
            sysSel_q   <= wstrb_i;
            strobed_q  <= 1'b0;
            state_q    <= WR_ACC;
          end else if (arvalid_i) begin
            arready_q <= 1'b1;
            rid_q     <= arid_i;
            sysAddr_q <= araddr_i;
            sysSel_q  <= 4'hF;
            strobed_q <= 1'b0;
            state_q   <= RD_ACC;
          end
        end

        WR_ACC: begin
          if (!strobed_q) begin
            sysWen_q  <= 1'b1;
            strobed_q <= 1'b1;
          end else if (accDone) begin
            bresp_q  <= accErr ? 2'b10 : 2'b00;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        RD_ACC: begin
          if (!strobed_q) begin
            sysRen_q  <= 1'b1;
            strobed_q <= 1'b1;
          end else if (accDone) begin
            rresp_q  <= accErr ? 2'b10 : 2'b00;
            rdata_q  <= accErr ? 32'h0 : sys_rdata_i;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign awready_o   = awready_q;
  assign wready_o    = wready_q;
  assign arready_o   = arready_q;
  assign bid_o       = bid_q;
  assign bresp_o     = bresp_q;
  assign bvalid_o    = bvalid_q;
  assign rid_o       = rid_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;
  assign rvalid_o    = rvalid_q;
  assign rlast_o     = rvalid_q;
  assign sys_addr_o  = sysAddr_q;
  assign sys_wdata_o = sysWdata_q;
  assign sys_sel_o   = sysSel_q;
  assign sys_wen_o   = sysWen_q;
  assign sys_ren_o   = sysRen_q;

endmodule

// File: doc/axi_sys_bridge.md
# axi_sys_bridge

Synthesizable AXI slave that terminates single-beat AXI transactions and converts them into one-cycle strobes on the simple system register bus used by the peripheral blocks. It sits directly downstream of an AXI master (the PS GP port in hardware, the AXI master model in benches) and feeds the register decoders. Response errors come from the peripheral or from an optional ack timeout.

## Interface

- IW, 4, AXI ID width; AWID/ARID are echoed on BID/RID. Address and data are fixed at 32 bits, strobe at 4 bits.
- TMO, 16, ack timeout in clock cycles, counted from the strobe cycle; legal range 1..255.
- aclk_i  in  1  clock; all logic on rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- awid_i  in  IW  write ID.
- awaddr_i  in  32  write byte address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wdata_i  in  32  write data.
- wstrb_i  in  4  write byte strobes.
- wvalid_i  in  1  write data valid (wlast not used; every beat is last).
- wready_o  out  1  write data ready.
- bid_o  out  IW  write response ID.
- bresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.
- arid_i  in  IW  read ID.
- araddr_i  in  32  read byte address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rid_o  out  IW  read response ID.
- rdata_o  out  32  read data.
- rresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR.
- rlast_o  out  1  high whenever rvalid_o is high.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.
- sys_addr_o  out  32  latched transaction address.
- sys_wdata_o  out  32  latched write data.
- sys_sel_o  out  4  byte select: wstrb for writes, 4'hF for reads.
- sys_wen_o  out  1  one-cycle write strobe.
- sys_ren_o  out  1  one-cycle read strobe.
- sys_rdata_i  in  32  read data, sampled when sys_ack_i is high.
- sys_err_i  in  1  access error, sampled in ACC states.
- sys_ack_i  in  1  access done, sampled in ACC states.

## Operation

- FSM states: IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP.
- IDLE: awvalid_i && wvalid_i both high: pulse awready_o and wready_o together for one cycle, latch ID, address, data and strobes, go to WR_ACC. AW without W, or W without AW: nothing is accepted; stay in IDLE. Otherwise arvalid_i high: pulse arready_o, latch ID and address, go to RD_ACC. A write that is ready has priority over a read.
- WR_ACC/RD_ACC: sys_wen_o or sys_ren_o is high in the first cycle only. sys_ack_i or sys_err_i is sampled from the strobe cycle onward. Termination moves to WR_RESP/RD_RESP, with resp 2'b10 if sys_err_i is high, else 2'b00. err wins over ack in the same cycle. On a read, rdata_o takes sys_rdata_i on OKAY and 32'h0 on SLVERR.
- WR_RESP/RD_RESP: bvalid_o/rvalid_o (and rlast_o) are held with stable ID, resp and data until bready_i/rready_i; then return to IDLE. No new address is accepted while a response is pending.
- sys_ack_i and sys_err_i are ignored outside the ACC states.

## Timing

- Reset: every output is 0, including sys_addr_o, sys_wdata_o, sys_sel_o, rdata_o and both resp outputs; FSM goes to IDLE.
- Reset mid-transaction: the transaction is abandoned, no strobe or response is issued, and the bridge restarts in IDLE.
- Write: valids seen in cycle 0, ready in cycle 1, sys_wen_o in cycle 2. With ack in cycle 2, bvalid_o rises in cycle 3. Read timing is identical.
- All outputs are registered; there is no combinational path from input to output.
- Timeout (macro set): the counter resets at the strobe. If there is no ack or err within TMO cycles, terminate with SLVERR in cycle strobe+TMO.

## Configuration

- AXI_SYS_BRIDGE_TMO_EN: when defined, the timeout counter and TMO-based SLVERR are compiled in. When undefined, the ACC states wait indefinitely for sys_ack_i or sys_err_i, and TMO is unused.

## Test plan

- Write: awaddr 0x40000010, wdata 0xDEADBEEF, wstrb 4'hF, id 3, ack in the strobe cycle -> one sys_wen_o pulse with sys_addr_o 0x40000010 and sys_sel_o 4'hF; bvalid_o in cycle 3 with bid_o 3 and bresp_o 0.
- Read: araddr 0x40000004, id 5, ack 2 cycles after the strobe with sys_rdata_i 0x12345678 -> rdata_o 0x12345678, rresp_o 0, rlast_o 1, rid_o 5. With sys_err_i instead of ack -> rresp_o 2'b10 and rdata_o 0.
- No ack, TMO=16, macro on -> rresp_o 2'b10 at strobe+16. Macro off, ack at strobe+100 -> rresp_o 0 at strobe+101.
- AW, W and AR valid in the same cycle, bready_i held low 5 cycles -> write served first; bvalid_o is held and arready_o stays 0 until the B handshake, then the read proceeds. arst_i pulse during RD_ACC -> all outputs 0 and no rvalid_o.
